// File: rtl/key_debouncer.sv
// Debounces one synchronized key level into a clean pressed level plus
// single-cycle press, release and long-press pulses.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter logic        ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic signal_sync,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldPre  = HoldW'(HOLD_CYCLES - 2);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    state_e           state_q, state_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             raw;

    assign raw = signal_sync ^ ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;

        // Hold time accrues across release bounces; saturation stops repeats.
        if ((state_q == StPressed || state_q == StReleaseWait) && hold_q != HoldLast) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HoldPre);
        end

        unique case (state_q)
            StReleased: begin
                if (raw) begin
                    state_d = StPressWait;
                    deb_d   = '0;
                end
            end
            StPressWait: begin
                if (!raw) begin
                    state_d = StReleased;
                end else if (deb_q == DebLast) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            StPressed: begin
                if (!raw) begin
                    state_d = StReleaseWait;
                    deb_d   = '0;
                end
            end
            StReleaseWait: begin
                if (raw) begin
                    state_d = StPressed;
                end else if (deb_q == DebLast) begin
                    state_d = StReleased;
                    rel_d   = 1'b1;
                    long_d  = 1'b0;  // release wins over a coincident long press
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = StReleased;
        endcase

        level_d = (state_d == StPressed) || (state_d == StReleaseWait);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StReleased;
            deb_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: active-low and active-high instances driven with
// complementary pins, checked against a run-length reference model.
module tb_key_debouncer;

    localparam int unsigned D = 4;
    localparam int unsigned H = 10;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic sig_l = 1'b1;
    logic sig_h = 1'b0;
    logic lv_l, pr_l, rl_l, lg_l;
    logic lv_h, pr_h, rl_h, lg_h;

    always #5 CLK = ~CLK;

    key_debouncer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW(1'b1)) dut_l (
        .CLK(CLK), .nRST(nRST), .signal_sync(sig_l),
        .level(lv_l), .press(pr_l), .release_pulse(rl_l), .long_press(lg_l)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW(1'b0)) dut_h (
        .CLK(CLK), .nRST(nRST), .signal_sync(sig_h),
        .level(lv_h), .press(pr_h), .release_pulse(rl_h), .long_press(lg_h)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_press, n_rel, n_long, cyc_press, cyc_long;

    // Reference: level flips after D+1 consecutive samples disagreeing with it.
    bit m_level, m_press, m_rel, m_long;
    int run, held;

    task automatic model_reset();
        m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
        run = 0; held = 0;
    endtask

    task automatic model_step(input bit r);
        bit was;
        was = m_level;
        m_press = 0; m_rel = 0; m_long = 0;
        if (was) held++;
        if (r != m_level) run++;
        else run = 0;
        if (run == D + 1) begin
            run = 0;
            if (m_level) m_rel = 1;
            else m_press = 1;
            m_level = !m_level;
        end
        if (was && !m_rel && held == H - 1) m_long = 1;
        if (m_press) held = 0;
    endtask

    task automatic check_one(input string tag, input logic [3:0] act, input logic [3:0] exp);
        string nm[4];
        nm[3] = "level"; nm[2] = "press"; nm[1] = "release"; nm[0] = "long_press";
        for (int i = 3; i >= 0; i--) begin
            tests++;
            if (act[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s.%s cyc=%0d got %b want %b", tag, nm[i], cyc, act[i], exp[i]);
            end
        end
    endtask

    task automatic check_both(input logic [3:0] exp);
        check_one("al1", {lv_l, pr_l, rl_l, lg_l}, exp);
        check_one("al0", {lv_h, pr_h, rl_h, lg_h}, exp);
    endtask

    task automatic check_count(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input bit r);
        sig_l = ~r;
        sig_h = r;
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_long = 0; cyc_press = -1; cyc_long = -1;
    endtask

    // One cycle: drive raw, clock, advance model, sample 1 time unit later.
    task automatic tick(input bit r, input bit use_tbl, input logic [3:0] tbl_exp);
        drive(r);
        @(posedge CLK);
        model_step(r);
        #1;
        cyc++;
        if (use_tbl) check_both(tbl_exp);
        else check_both({m_level, m_press, m_rel, m_long});
        if (pr_l) begin n_press++; cyc_press = cyc; end
        if (rl_l) n_rel++;
        if (lg_l) begin n_long++; cyc_long = cyc; end
    endtask

    task automatic run_raw(input bit r, input int n);
        for (int i = 0; i < n; i++) tick(r, 1'b0, 4'b0000);
    endtask

    typedef struct {
        bit         raw;
        logic [3:0] exp;  // {level, press, release, long_press}
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit val;
        int len;

        for (int i = 0; i < 14; i++) begin
            tbl[i].raw = (i < 8);
            tbl[i].exp = 4'b0000;
        end
        tbl[4].exp = 4'b1100;
        for (int i = 5; i < 12; i++) tbl[i].exp = 4'b1000;
        tbl[12].exp = 4'b0010;

        // Reset held with toggling input.
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive(i[0]);
            @(posedge CLK);
            #1;
            check_both(4'b0000);
        end
        drive(1'b0);
        nRST = 1'b1;
        clear_counts();
        run_raw(1'b0, 20);
        check_count("reset_quiet_pulses", n_press + n_rel + n_long, 0);

        // Clean press/release from the table.
        for (int i = 0; i < 14; i++) tick(tbl[i].raw, 1'b1, tbl[i].exp);

        // Bounce on press: pin 0,1,0,0,1,0,0,0,0 then steady.
        clear_counts();
        begin
            bit seq[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 9; i++) tick(seq[i], 1'b0, 4'b0000);
        end
        check_count("bounce_no_early_press", n_press, 0);
        run_raw(1'b1, 3);
        check_count("bounce_one_press", n_press, 1);
        // Short release glitch while pressed.
        run_raw(1'b0, 3);
        run_raw(1'b1, 3);
        check_count("glitch_no_release", n_rel, 0);
        check_count("glitch_level", lv_l, 1);
        run_raw(1'b0, 6);

        // Long press, then one release.
        clear_counts();
        run_raw(1'b1, 35);
        check_count("long_once", n_long, 1);
        check_count("long_delay", cyc_long - cyc_press, H - 1);
        run_raw(1'b0, 6);
        check_count("long_then_release", n_rel, 1);

        // Hold threshold lands on the release edge: release wins.
        clear_counts();
        run_raw(1'b1, 5 + 4);
        run_raw(1'b0, 6);
        check_count("coincide_release", n_rel, 1);
        check_count("coincide_no_long", n_long, 0);

        // Reset in the middle of the press debounce.
        clear_counts();
        run_raw(1'b1, 3);
        #2 nRST = 1'b0;
        #1;
        check_both(4'b0000);
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b1;
        run_raw(1'b1, 4);
        check_count("reset_mid_no_press", n_press, 0);
        run_raw(1'b1, 1);
        check_count("reset_mid_full_press", n_press, 1);
        run_raw(1'b0, 6);

        // Randomized bursts.
        val = 1'b0;
        for (int b = 0; b < 300; b++) begin
            val = ~val;
            if ($urandom_range(0, 4) == 0) len = int'($urandom_range(8, 16));
            else len = int'($urandom_range(1, 7));
            run_raw(val, len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounces one already-synchronized pushbutton/switch level and turns it into a clean level plus single-cycle press, release and long-press event pulses. Sits directly downstream of the two-flop input synchronizer on each DE10 KEY/SW input and feeds control logic that needs one event per physical actuation. Bounce rejection uses a per-state cycle counter; long-press detection uses a separate saturating hold counter.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a change (5 ms at 50 MHz); must be ≥ 2
- HOLD_CYCLES, 50000000: cycles of accepted press before long_press fires (1 s at 50 MHz); must be ≥ 2
- ACTIVE_LOW, 1'b1: 1 means signal_sync = 0 is "pressed" (DE10 KEYs), 0 means active-high

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous, active-low reset
- signal_sync  input  1  synchronized raw key level, already in CLK domain
- level  output  1  debounced pressed state, 1 = pressed regardless of ACTIVE_LOW
- press  output  1  one-cycle pulse on accepted press
- release  output  1  one-cycle pulse on accepted release
- long_press  output  1  one-cycle pulse once per press after HOLD_CYCLES

## Operation
- raw = signal_sync XOR ACTIVE_LOW; raw = 1 means pressed.
- deb_cnt width $clog2(DEBOUNCE_CYCLES); hold_cnt width $clog2(HOLD_CYCLES); both unsigned, never wrap.
- States: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED: raw = 1 → PRESS_WAIT, deb_cnt ← 0.
- PRESS_WAIT: raw = 0 → RELEASED (bounce rejected, no pulse). raw = 1 and deb_cnt = DEBOUNCE_CYCLES-1 → PRESSED, press ← 1, hold_cnt ← 0. Otherwise deb_cnt increments.
- PRESSED: raw = 0 → RELEASE_WAIT, deb_cnt ← 0. hold_cnt increments while < HOLD_CYCLES-1 in PRESSED and RELEASE_WAIT; on the edge it becomes HOLD_CYCLES-1, long_press ← 1. Saturates there; no repeat.
- RELEASE_WAIT: raw = 1 → PRESSED (bounce rejected, no pulse; hold_cnt keeps its value). raw = 0 and deb_cnt = DEBOUNCE_CYCLES-1 → RELEASED, release ← 1. Otherwise deb_cnt increments.
- level = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- press, release, long_press default to 0 each cycle; all outputs registered.
- Simultaneous events: long_press and release never coincide. If the hold threshold is reached on the same edge as the RELEASE_WAIT → RELEASED transition, release wins and long_press is suppressed.

## Timing
- Reset (async assert, sync deassert by upstream): state RELEASED, deb_cnt = 0, hold_cnt = 0, level = 0, press = 0, release = 0, long_press = 0. Reset mid-press discards all progress; no pulse is emitted on or after reset.
- Let E0 be the first edge sampling raw = 1 in RELEASED. press and level rise after edge E0+DEBOUNCE_CYCLES if raw stays 1 through that edge. press lasts exactly 1 cycle.
- Release latency is symmetric: release pulses after edge R0+DEBOUNCE_CYCLES, where R0 is the first edge sampling raw = 0 in PRESSED. level falls in the same cycle.
- long_press is asserted HOLD_CYCLES-1 cycles after press, counting stable PRESSED/RELEASE_WAIT time.
- Any raw glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- End-to-end from the pin adds the upstream synchronizer's 2 cycles.

## Test plan
Run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1.

- Reset check: hold nRST=0 with signal_sync toggling → all outputs 0; release reset with signal_sync=1 → no pulses for 20 cycles.
- Clean press: drive signal_sync 0 from edge E0 → press=1 only in the cycle after E0+4 and level=1 from then. Release it (1) at R0 → release=1 one cycle after R0+4 and level=0.
- Bounce rejection: drive signal_sync 0,1,0,0,1,0,0,0,0 → exactly one press, only after the final 4-cycle stable run; a 3-cycle release glitch while pressed → no release and level stays 1.
- Long press: hold pressed for 30 cycles → long_press exactly once, 9 cycles after press; no repeat; one release at the end.
- Reset mid-operation: assert nRST in PRESS_WAIT (deb_cnt=2) → no press. After deassertion, a full 4-cycle press is required again.
- ACTIVE_LOW=0 rerun of the clean-press case with inverted stimulus → identical output waveform.
